// File: rtl/i2c_angle_target_pkg.sv
// Shared I2C constants for the angle-encoder target and the pwm_ctrl initiator.
package i2c_angle_target_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h36;
    localparam logic [7:0] ANGLE_HI         = 8'h0E;
    localparam logic [7:0] ANGLE_LO         = 8'h0F;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WRITE_IGN,
        ST_TX,
        ST_MACK,
        ST_IGNORE,
        ST_WAIT_STOP
    } i2c_state_t;

    // Register map of the emulated encoder: high nibble register, low byte register, zeros elsewhere.
    function automatic logic [7:0] angle_reg_byte(
        input logic [7:0]  ptr,
        input logic [11:0] ang,
        input logic [7:0]  hi_addr,
        input logic [7:0]  lo_addr
    );
        logic [7:0] result;
        result = '0;
        if (ptr == hi_addr)
            result = {4'h0, ang[11:8]};
        else if (ptr == lo_addr)
            result = ang[7:0];
        return result;
    endfunction

endpackage

// File: rtl/i2c_angle_target_pin_sync.sv
// Synchronizes the asynchronous sck/sda pins and detects sck edges plus START/STOP.
module i2c_pin_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic sck,
    input  logic sda_in,
    output logic sda_level,
    output logic sck_rise,
    output logic sck_fall,
    output logic start_det,
    output logic stop_det
);

    // [0] first sync stage, [1] synchronized value, [2] previous synchronized value
    logic [2:0] sck_pipe;
    logic [2:0] sda_pipe;

    // Two-flop synchronizers plus history flop; reset to the idle (released) bus level.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sck_pipe <= '1;
            sda_pipe <= '1;
        end else begin
            sck_pipe <= {sck_pipe[1:0], sck};
            sda_pipe <= {sda_pipe[1:0], sda_in};
        end
    end

    // Edge and bus-condition decode; START/STOP need sck high both before and now.
    always_comb begin
        sda_level = sda_pipe[1];
        sck_rise  = sck_pipe[1] & ~sck_pipe[2];
        sck_fall  = ~sck_pipe[1] & sck_pipe[2];
        start_det = sck_pipe[1] & sck_pipe[2] & sda_pipe[2] & ~sda_pipe[1];
        stop_det  = sck_pipe[1] & sck_pipe[2] & ~sda_pipe[2] & sda_pipe[1];
    end

endmodule

// File: rtl/i2c_angle_target.sv
// I2C target emulating the magnetic encoder's angle registers from a live 12-bit angle.
module i2c_angle_target
    import i2c_angle_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter logic [7:0] HI_REG   = ANGLE_HI,
    parameter logic [7:0] LO_REG   = ANGLE_LO
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sck,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [11:0] angle,
    output logic        busy,
    output logic        rd_done
);

    logic sda_level;
    logic sck_rise;
    logic sck_fall;
    logic start_det;
    logic stop_det;

    i2c_pin_sync u_pin_sync (
        .clock     (clock),
        .reset_n   (reset_n),
        .sck       (sck),
        .sda_in    (sda_in),
        .sda_level (sda_level),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_t  state;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  reg_ptr;
    logic [11:0] snap;
    logic [7:0]  first_byte;
    logic [7:0]  next_byte;

    // First read byte comes from the live angle (captured into snap on the same edge);
    // later bytes come from the snapshot so hi/lo never tear.
    always_comb begin
        first_byte = angle_reg_byte(reg_ptr, angle, HI_REG, LO_REG);
        next_byte  = angle_reg_byte(reg_ptr, snap, HI_REG, LO_REG);
    end

    // Protocol FSM; sda_oe only changes on sck falling edges, START/STOP override everything.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            reg_ptr <= HI_REG;
            snap    <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            rd_done <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            if (stop_det) begin
                state   <= ST_IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else if (start_det) begin
                state   <= ST_ADDR;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_IGNORE, ST_WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end
                    ST_ADDR, ST_PTR, ST_WRITE_IGN: begin
                        if (sck_rise) begin
                            shift   <= {shift[6:0], sda_level};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (sck_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (state == ST_ADDR) begin
                                if (shift[7:1] == DEV_ADDR) begin
                                    state  <= ST_ADDR_ACK;
                                    sda_oe <= 1'b1;
                                    busy   <= 1'b1;
                                end else begin
                                    state  <= ST_IGNORE;
                                end
                            end else begin
                                if (state == ST_PTR)
                                    reg_ptr <= shift;
                                state  <= ST_PTR_ACK;
                                sda_oe <= 1'b1;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (sck_fall) begin
                            bit_cnt <= '0;
                            if (shift[0]) begin
                                snap   <= angle;
                                shift  <= first_byte;
                                sda_oe <= ~first_byte[7];
                                state  <= ST_TX;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_PTR;
                            end
                        end
                    end
                    ST_PTR_ACK: begin
                        if (sck_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= ST_WRITE_IGN;
                        end
                    end
                    ST_TX: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (sck_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_MACK;
                            end else begin
                                shift  <= {shift[6:0], 1'b0};
                                sda_oe <= ~shift[6];
                            end
                        end
                    end
                    ST_MACK: begin
                        // Pointer advances once per byte sent; the decision is made on the
                        // rise but the next byte is only driven on the following fall.
                        if (sck_rise) begin
                            reg_ptr <= reg_ptr + 8'd1;
                            if (sda_level) begin
                                rd_done <= 1'b1;
                                busy    <= 1'b0;
                                state   <= ST_WAIT_STOP;
                            end else begin
                                bit_cnt <= 4'd1;
                            end
                        end else if (sck_fall && bit_cnt == 4'd1) begin
                            shift   <= next_byte;
                            sda_oe  <= ~next_byte[7];
                            bit_cnt <= '0;
                            state   <= ST_TX;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_angle_target.sv
// Directed bench for i2c_angle_target: bit-banged I2C initiator with hand-computed expectations.
module tb_i2c_angle_target;
    import i2c_angle_target_pkg::*;

    localparam int Q = 100;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        sck     = 1'b1;
    logic        sda_m   = 1'b1;
    logic [11:0] angle   = '0;
    logic        sda_oe;
    logic        busy;
    logic        rd_done;
    logic        sda_in;

    int   checks   = 0;
    int   errors   = 0;
    int   rd_cnt   = 0;
    logic saw_oe   = 1'b0;
    logic saw_busy = 1'b0;

    assign sda_in = sda_m & ~sda_oe;

    i2c_angle_target dut (
        .clock   (clock),
        .reset_n (reset_n),
        .sck     (sck),
        .sda_in  (sda_in),
        .sda_oe  (sda_oe),
        .angle   (angle),
        .busy    (busy),
        .rd_done (rd_done)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rd_done) rd_cnt++;
        if (sda_oe) saw_oe = 1'b1;
        if (busy) saw_busy = 1'b1;
    end

    task automatic i2c_start;
        sda_m = 1'b1; #Q;
        sck   = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        sck   = 1'b0; #Q;
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; #Q;
        sck   = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #Q;
        sck   = 1'b1; #(2*Q);
        sck   = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q;
        sck   = 1'b1; #Q;
        b     = sda_in; #Q;
        sck   = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL reset_rd_done got %b want 0", rd_done); end
        checks++; if (dut.reg_ptr !== 8'h0E) begin errors++; $display("FAIL reset_reg_ptr got %h want 0e", dut.reg_ptr); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_ptr_then_read;
        logic ack;
        logic [7:0] d;
        int rd0;
        rd0 = rd_cnt;
        angle = 12'hA5C;
        i2c_start;
        write_byte(8'h6C, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL t1_addr_w_ack got %b want 0", ack); end
        write_byte(8'h0E, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL t1_ptr_ack got %b want 0", ack); end
        i2c_start;
        write_byte(8'h6D, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL t1_addr_r_ack got %b want 0", ack); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %b want 1", busy); end
        read_byte(1'b0, d);
        checks++; if (d !== 8'h0A) begin errors++; $display("FAIL t1_byte_hi got %h want 0a", d); end
        read_byte(1'b1, d);
        checks++; if (d !== 8'h5C) begin errors++; $display("FAIL t1_byte_lo got %h want 5c", d); end
        i2c_stop;
        repeat (5) @(negedge clock);
        checks++; if (rd_cnt - rd0 !== 1) begin errors++; $display("FAIL t1_rd_done_count got %0d want 1", rd_cnt - rd0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_end got %b want 0", busy); end
    endtask

    task automatic test_wrong_addr;
        logic ack;
        logic [7:0] d;
        saw_oe = 1'b0;
        saw_busy = 1'b0;
        i2c_start;
        write_byte(8'h6F, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL t2_addr_nack got %b want 1", ack); end
        read_byte(1'b1, d);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL t2_idle_bus got %h want ff", d); end
        i2c_stop;
        repeat (5) @(negedge clock);
        checks++; if (saw_oe !== 1'b0) begin errors++; $display("FAIL t2_sda_oe_seen got %b want 0", saw_oe); end
        checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL t2_busy_seen got %b want 0", saw_busy); end
    endtask

    task automatic test_no_tearing;
        logic ack;
        logic [7:0] d;
        angle = 12'h123;
        i2c_start;
        write_byte(8'h6C, ack);
        write_byte(8'h0E, ack);
        i2c_start;
        write_byte(8'h6D, ack);
        read_byte(1'b0, d);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL t3_byte_hi got %h want 01", d); end
        angle = 12'hFED;
        read_byte(1'b1, d);
        checks++; if (d !== 8'h23) begin errors++; $display("FAIL t3_byte_lo got %h want 23", d); end
        i2c_stop;
    endtask

    task automatic test_ptr_wrap;
        logic ack;
        logic [7:0] d;
        int rd0;
        rd0 = rd_cnt;
        angle = 12'hFFF;
        i2c_start;
        write_byte(8'h6C, ack);
        write_byte(8'hFF, ack);
        checks++; if (dut.reg_ptr !== 8'hFF) begin errors++; $display("FAIL t4_ptr_written got %h want ff", dut.reg_ptr); end
        i2c_start;
        write_byte(8'h6D, ack);
        read_byte(1'b0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL t4_byte_ff got %h want 00", d); end
        checks++; if (dut.reg_ptr !== 8'h00) begin errors++; $display("FAIL t4_ptr_wrap got %h want 00", dut.reg_ptr); end
        read_byte(1'b1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL t4_byte_00 got %h want 00", d); end
        checks++; if (dut.reg_ptr !== 8'h01) begin errors++; $display("FAIL t4_ptr_next got %h want 01", dut.reg_ptr); end
        i2c_stop;
        repeat (5) @(negedge clock);
        checks++; if (rd_cnt - rd0 !== 1) begin errors++; $display("FAIL t4_rd_done_count got %0d want 1", rd_cnt - rd0); end
    endtask

    task automatic test_reset_mid_tx;
        logic ack;
        logic [7:0] d;
        angle = 12'h5A3;
        i2c_start;
        write_byte(8'h6C, ack);
        write_byte(8'h0E, ack);
        i2c_start;
        write_byte(8'h6D, ack);
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL t5_driving_zero got %b want 1", sda_oe); end
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL t5_release got %b want 0", sda_oe); end
        checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL t5_state got %0d want %0d", dut.state, ST_IDLE); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy got %b want 0", busy); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        i2c_stop;
        i2c_start;
        write_byte(8'h6D, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL t5_addr_ack got %b want 0", ack); end
        read_byte(1'b0, d);
        checks++; if (d !== 8'h05) begin errors++; $display("FAIL t5_byte_hi got %h want 05", d); end
        read_byte(1'b1, d);
        checks++; if (d !== 8'hA3) begin errors++; $display("FAIL t5_byte_lo got %h want a3", d); end
        i2c_stop;
    endtask

    task automatic test_stop_mid_tx;
        logic ack;
        logic b;
        int rd0;
        angle = 12'hA5C;
        i2c_start;
        write_byte(8'h6C, ack);
        write_byte(8'h0E, ack);
        i2c_start;
        write_byte(8'h6D, ack);
        for (int i = 0; i < 4; i++) read_bit(b);
        rd0 = rd_cnt;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t6_busy_pre got %b want 1", busy); end
        sda_m = 1'b0; #Q;
        sck   = 1'b1; #Q;
        @(negedge clock);
        sda_m = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t6_busy_latency got %b want 1", busy); end
        @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy_post got %b want 0", busy); end
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL t6_sda_oe got %b want 0", sda_oe); end
        checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL t6_state got %0d want %0d", dut.state, ST_IDLE); end
        repeat (5) @(negedge clock);
        checks++; if (rd_cnt !== rd0) begin errors++; $display("FAIL t6_no_rd_done got %0d want %0d", rd_cnt, rd0); end
    endtask

    initial begin
        @(negedge clock);
        test_reset;
        test_ptr_then_read;
        test_wrong_addr;
        test_no_tearing;
        test_ptr_wrap;
        test_reset_mid_tx;
        test_stop_mid_tx;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
